// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package alu_mul_seq_pkg;

    localparam int MUL_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Control word of the team ALU (zero/negate x, zero/negate y, add/and, negate out)
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = '{zx: 1'b0, nx: 1'b0, zy: 1'b0, ny: 1'b0, f: 1'b1, no: 1'b0};

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result bundle of the multiplier: start with operands in, status and product out.
interface alu_mul_seq_if #(parameter int WIDTH = 16);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             zr;
    logic             ng;

    modport master (
        output start, a, b,
        input  busy, done, product, zr, ng
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, zr, ng
    );

endinterface

// File: rtl/alu_mul_seq_alu.sv
// Team combinational ALU: optional zero/negate on each input, add or AND, optional negate of result.
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  alu_ctrl_t        i_ctrl,
    output logic [WIDTH-1:0] o_out
);

    logic [WIDTH-1:0] w_x0;
    logic [WIDTH-1:0] w_x1;
    logic [WIDTH-1:0] w_y0;
    logic [WIDTH-1:0] w_y1;
    logic [WIDTH-1:0] w_f;

    // Input conditioning, function select and output negation
    always_comb begin
        w_x0  = i_ctrl.zx ? '0 : i_x;
        w_x1  = i_ctrl.nx ? ~w_x0 : w_x0;
        w_y0  = i_ctrl.zy ? '0 : i_y;
        w_y1  = i_ctrl.ny ? ~w_y0 : w_y0;
        w_f   = i_ctrl.f ? (w_x1 + w_y1) : (w_x1 & w_y1);
        o_out = i_ctrl.no ? ~w_f : w_f;
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier returning the low WIDTH bits of a*b.
// Iterates only until the remaining multiplier bits are zero, so RUN lasts
// msb_index(b)+1 cycles (minimum one).
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_reset,
    alu_mul_seq_if.slave bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_product;
    logic             r_zr;
    logic             r_ng;

    logic             w_accept;
    logic [WIDTH-1:0] w_alu_out;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_mplier_next;
    logic             w_last;

    // A new request is taken only when not iterating
    assign w_accept      = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_mplier_next = r_mplier >> 1;
    assign w_acc_next    = r_mplier[0] ? w_alu_out : r_acc;
    assign w_last        = (w_mplier_next == '0);

    alu_mul_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_x    (r_acc),
        .i_y    (r_mcand),
        .i_ctrl (ALU_ADD),
        .o_out  (w_alu_out)
    );

    // State register; reset wins over everything, including an active RUN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = w_accept ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, shift/accumulate iteration and result latch on the final RUN cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_zr      <= 1'b1;
            r_ng      <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_next;
            if (w_last) begin
                r_product <= w_acc_next;
                r_zr      <= (w_acc_next == '0);
                r_ng      <= w_acc_next[WIDTH-1];
            end
        end
    end

    assign bus.busy    = (r_state == ST_RUN);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.product = r_product;
    assign bus.zr      = r_zr;
    assign bus.ng      = r_ng;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: driver pushes expected results, monitor checks them on done.
module tb_alu_mul_seq;

    typedef struct {
        logic [15:0] p;
        logic        zr;
        logic        ng;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic reset;
    int unsigned cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];
    logic [15:0] hold_p;
    logic        hold_zr;
    logic        hold_ng;

    alu_mul_seq_if u_if ();

    alu_mul_seq u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain modular product; run length = highest set bit index + 1, at least 1
    function automatic int ref_k(input logic [15:0] b);
        int k;
        k = 1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) k = i + 1;
        end
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply from an accepting state; returns in the DONE cycle
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold);
        exp_t e;
        int   k;
        logic [31:0] full;
        k     = ref_k(b);
        full  = 32'(a) * 32'(b);
        e.p   = full[15:0];
        e.zr  = (e.p == 16'h0000);
        e.ng  = e.p[15];
        e.cyc = cyc + 1 + k;
        sb_q.push_back(e);
        u_if.start = 1'b1;
        u_if.a     = a;
        u_if.b     = b;
        tick();
        u_if.start = hold;
        for (int i = 0; i < k; i++) begin
            u_if.a = 16'($urandom);
            u_if.b = 16'($urandom);
            check("busy_in_run", 32'(u_if.busy), 32'd1);
            tick();
        end
        u_if.start = 1'b0;
    endtask

    // Monitor: pops on every done, otherwise requires the result registers to hold
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_exclusive", 32'(u_if.busy & u_if.done), 32'd0);
        if (reset) begin
            hold_p  = 16'h0000;
            hold_zr = 1'b1;
            hold_ng = 1'b0;
        end else if (u_if.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("product", 32'(u_if.product), 32'(e.p));
                check("zr", 32'(u_if.zr), 32'(e.zr));
                check("ng", 32'(u_if.ng), 32'(e.ng));
                hold_p  = e.p;
                hold_zr = e.zr;
                hold_ng = e.ng;
            end
        end else begin
            check("result_hold", {14'd0, u_if.zr, u_if.ng, u_if.product}, {14'd0, hold_zr, hold_ng, hold_p});
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          msb;
        reset      = 1'b1;
        u_if.start = 1'b0;
        u_if.a     = 16'h0000;
        u_if.b     = 16'h0000;
        tick();
        tick();
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_product", 32'(u_if.product), 32'h0);
        check("rst_zr", 32'(u_if.zr), 32'd1);
        check("rst_ng", 32'(u_if.ng), 32'd0);
        reset = 1'b0;
        tick();

        run_op(16'd7, 16'd6, 1'b0);            tick();
        run_op(16'h1234, 16'h0000, 1'b0);      tick();
        run_op(16'hFFFD, 16'd5, 1'b0);         tick();
        run_op(16'd5, 16'hFFFD, 1'b0);         tick();
        run_op(16'h0100, 16'h0100, 1'b0);      tick();
        run_op(16'd3, 16'h000F, 1'b1);         tick(); tick();

        // Abort a long op with reset; no done may follow
        u_if.start = 1'b1;
        u_if.a     = 16'h1234;
        u_if.b     = 16'h8000;
        tick();
        u_if.start = 1'b0;
        tick();
        tick();
        check("pre_abort_busy", 32'(u_if.busy), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(u_if.busy), 32'd0);
        check("abort_done", 32'(u_if.done), 32'd0);
        check("abort_product", 32'(u_if.product), 32'h0);
        check("abort_zr", 32'(u_if.zr), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        // Back-to-back: second start issued in the DONE cycle of the first
        run_op(16'd9, 16'd9, 1'b0);
        run_op(16'd2, 16'd3, 1'b0);
        tick();

        for (int n = 0; n < 40; n++) begin
            msb = $urandom_range(0, 16);
            ra  = 16'($urandom);
            rb  = 16'($urandom & ((32'd1 << msb) - 32'd1));
            run_op(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) begin
                for (int g = 0; g <= $urandom_range(0, 3); g++) tick();
            end
        end

        for (int i = 0; i < 5; i++) tick();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/product width (only 16 is required to be supported).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request a multiply; sampled on rising clk edge.
REQ-005 a  in  16  multiplicand, two's complement or unsigned.
REQ-006 b  in  16  multiplier, two's complement or unsigned.
REQ-007 busy  out  1  high while a multiply is iterating (state RUN).
REQ-008 done  out  1  one-cycle pulse: product/zr/ng valid.
REQ-009 product  out  16  low 16 bits of a*b, registered, held until next accepted start.
REQ-010 zr  out  1  product == 0, registered with product.
REQ-011 ng  out  1  product[15], registered with product.
REQ-012 Clocking and reset are decided: one clock; reset is synchronous and active-high.

Function
REQ-013 FSM states IDLE, RUN, DONE; encoding free.
REQ-014 start is accepted only in IDLE or DONE; start in RUN is ignored with no side effect.
REQ-015 On accept: mcand<=a, mplier<=b, acc<=0, state<=RUN; a/b may change afterwards without effect.
REQ-016 Each RUN cycle: if mplier[0]=1 then acc<=acc+mcand (via ALU add); mcand<=mcand<<1; mplier<=mplier>>1 (logical).
REQ-017 RUN->DONE after the RUN cycle whose updated mplier is zero; RUN lasts k = max(1, msb_index(b)+1) cycles, k<=16.
REQ-018 Accept cycle = cycle 0; RUN occupies cycles 1..k; DONE is cycle k+1, with done=1 and product/zr/ng updated on entry to DONE.
REQ-019 DONE->IDLE next cycle unless start is accepted in DONE (then ->RUN, back-to-back, no idle bubble).
REQ-020 done is high only in DONE; busy is high only in RUN; never both high.
REQ-021 Arithmetic modulo 2^16: overflow bits discarded silently; no overflow flag; signed and unsigned results identical in 16 bits.
REQ-022 product/zr/ng change only on entry to DONE or on reset.

Reset
REQ-023 reset has priority over start and all FSM activity, including mid-RUN.
REQ-024 Reset values: state=IDLE, busy=0, done=0, product=0x0000, zr=1, ng=0; acc/mcand/mplier=0.
REQ-025 Reset during RUN aborts the operation; no done pulse follows.

Structure
REQ-026 Shared package/header holds WIDTH, FSM state constants, and the ALU add control word (zx=0,nx=0,zy=0,ny=0,f=1,no=0).
REQ-027 One sub-module: the team's existing 16-bit ALU, instantiated once with x=acc, y=mcand and the add control word; its out drives the acc update.
REQ-028 Shifts, FSM and output registers live in alu_mul_seq; no other sub-modules.

Verification
REQ-029 a=7, b=6, start 1 cycle -> k=3, busy cycles 1-3, done in cycle 4, product=0x002A, zr=0, ng=0.
REQ-030 a=0x1234, b=0 -> k=1, done in cycle 2, product=0x0000, zr=1, ng=0.
REQ-031 a=0xFFFD (-3), b=5 -> k=3, product=0xFFF1, ng=1, zr=0; a=5, b=0xFFFD -> k=16, product=0xFFF1.
REQ-032 a=0x0100, b=0x0100 -> k=9, product=0x0000 (overflow), zr=1.
REQ-033 a=3, b=0x000F, start held high through RUN -> only one multiply, product=0x002D; then reset asserted mid-RUN of a new op -> IDLE next cycle, busy=0, product=0, zr=1, no done.
REQ-034 Back-to-back: start with a=2, b=3 asserted in DONE cycle of a prior op -> RUN next cycle, product=0x0006 after k=2, exactly one done per op.
